// File: rtl/imuldiv_muldiv_requester_pkg.sv
// Shared definitions for the mul/div requester.
//   - FUNC_* : muldivreq function encodings seen on cmd_fn / muldivreq_msg_fn
//   - RESULT_LO_* / RESULT_HI_* : bit ranges of the two halves of a 64-bit unit result
//   - wb_state_e : writeback buffer states
//   - sel_hi() : which half of the result a command wants back
//   - pick_half() : extracts that half
package imuldiv_muldiv_requester_pkg;

  localparam logic [2:0] FUNC_MUL  = 3'd0;
  localparam logic [2:0] FUNC_DIV  = 3'd1;
  localparam logic [2:0] FUNC_DIVU = 3'd2;
  localparam logic [2:0] FUNC_REM  = 3'd3;
  localparam logic [2:0] FUNC_REMU = 3'd4;

  // MUL returns the full product; DIV*/REM* return {remainder, quotient}.
  localparam int RESULT_LO_MSB = 31;
  localparam int RESULT_LO_LSB = 0;
  localparam int RESULT_HI_MSB = 63;
  localparam int RESULT_HI_LSB = 32;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

  function automatic logic sel_hi(input logic [2:0] fn, input logic hi);
    logic sel;
    case (fn)
      FUNC_MUL:             sel = hi;
      FUNC_DIV, FUNC_DIVU:  sel = 1'b0;
      FUNC_REM, FUNC_REMU:  sel = 1'b1;
      default:              sel = 1'b0;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] pick_half(input logic [63:0] result, input logic sel);
    return sel ? result[RESULT_HI_MSB:RESULT_HI_LSB] : result[RESULT_LO_MSB:RESULT_LO_LSB];
  endfunction

endpackage

// File: rtl/imuldiv_muldiv_requester_meta_fifo.sv
// In-order metadata FIFO for requests in flight to the mul/div unit.
// Ports:
//   clk, reset       clock, synchronous active-low reset (clears pointers and count)
//   push, push_data  write one entry; ignored while full
//   pop              drop the head entry; ignored while empty
//   head             current head entry
//   full, empty      status, derived from the registered count only
//   count            number of stored entries
module imuldiv_muldiv_requester_meta_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 6,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imuldiv_muldiv_requester.sv
// Initiator side of the muldivreq/muldivresp val/rdy protocol. Commands pass straight
// through to the unit; their {rd, sel_hi} metadata is queued in order and joined with
// each response to fill a one-entry, back-pressurable writeback register.
// Ports:
//   clk, reset                   clock, synchronous active-low reset
//   cmd_*                        command from execute: fn, a, b, rd, hi (val/rdy)
//   muldivreq_*                  request to the unit (operands are pass-through)
//   muldivresp_*                 response from the unit (64-bit result)
//   wb_val/wb_rdy/wb_rd/wb_data  registered writeback port
//   pend_cnt                     requests in flight
//   busy                         anything in flight or waiting to write back
//   err                          sticky: response arrived with nothing in flight
//
// Writeback buffer states:
//   state    | meaning
//   WB_EMPTY | no result held, wb_val=0
//   WB_FULL  | result held in wb_rd/wb_data, wb_val=1
module imuldiv_muldiv_requester
  import imuldiv_muldiv_requester_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RD_W  = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_val,
  output logic                         cmd_rdy,
  input  logic [2:0]                   cmd_fn,
  input  logic [31:0]                  cmd_a,
  input  logic [31:0]                  cmd_b,
  input  logic [RD_W-1:0]              cmd_rd,
  input  logic                         cmd_hi,
  output logic [2:0]                   muldivreq_msg_fn,
  output logic [31:0]                  muldivreq_msg_a,
  output logic [31:0]                  muldivreq_msg_b,
  output logic                         muldivreq_val,
  input  logic                         muldivreq_rdy,
  input  logic [63:0]                  muldivresp_msg_result,
  input  logic                         muldivresp_val,
  output logic                         muldivresp_rdy,
  output logic                         wb_val,
  input  logic                         wb_rdy,
  output logic [RD_W-1:0]              wb_rd,
  output logic [31:0]                  wb_data,
  output logic [$clog2(DEPTH+1)-1:0]   pend_cnt,
  output logic                         busy,
  output logic                         err
);

  localparam int META_W = RD_W + 1;

  logic              full;
  logic              empty;
  logic [META_W-1:0] head;
  logic              cmd_fire;
  logic              resp_fire;
  logic              resp_pop;
  logic              resp_orphan;
  wb_state_e         state_q;
  wb_state_e         state_d;

  assign muldivreq_msg_fn = cmd_fn;
  assign muldivreq_msg_a  = cmd_a;
  assign muldivreq_msg_b  = cmd_b;

  // Gated by the registered full flag only, so a response draining this cycle
  // never creates a combinational path into the request side.
  assign muldivreq_val = reset && cmd_val && !full;
  assign cmd_rdy       = reset && muldivreq_rdy && !full;
  assign cmd_fire      = cmd_val && cmd_rdy;

  assign muldivresp_rdy = reset && (!wb_val || wb_rdy);
  assign resp_fire      = muldivresp_val && muldivresp_rdy;
  assign resp_pop       = resp_fire && !empty;
  assign resp_orphan    = resp_fire && empty;

  imuldiv_muldiv_requester_meta_fifo #(
    .DEPTH (DEPTH),
    .W     (META_W)
  ) u_meta_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_fire),
    .push_data ({cmd_rd, sel_hi(cmd_fn, cmd_hi)}),
    .pop       (resp_pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (pend_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= WB_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_EMPTY: if (resp_pop) state_d = WB_FULL;
      WB_FULL: begin
        if (resp_pop)    state_d = WB_FULL;
        else if (wb_rdy) state_d = WB_EMPTY;
      end
      default:  state_d = WB_EMPTY;
    endcase
  end

  assign wb_val = (state_q == WB_FULL);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_rd   <= '0;
      wb_data <= '0;
      err     <= 1'b0;
    end else begin
      if (resp_pop) begin
        wb_rd   <= head[META_W-1:1];
        wb_data <= pick_half(muldivresp_msg_result, head[0]);
      end
      if (resp_orphan) err <= 1'b1;
    end
  end

  assign busy = (pend_cnt != '0) || wb_val;

endmodule

// File: tb/tb_imuldiv_muldiv_requester.sv
module tb_imuldiv_muldiv_requester;
  import imuldiv_muldiv_requester_pkg::*;

  localparam int DEPTH = 2;
  localparam int RD_W  = 5;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              cmd_val, cmd_rdy, cmd_hi;
  logic [2:0]        cmd_fn;
  logic [31:0]       cmd_a, cmd_b;
  logic [RD_W-1:0]   cmd_rd;
  logic [2:0]        muldivreq_msg_fn;
  logic [31:0]       muldivreq_msg_a, muldivreq_msg_b;
  logic              muldivreq_val, muldivreq_rdy;
  logic [63:0]       muldivresp_msg_result;
  logic              muldivresp_val, muldivresp_rdy;
  logic              wb_val, wb_rdy;
  logic [RD_W-1:0]   wb_rd;
  logic [31:0]       wb_data;
  logic [1:0]        pend_cnt;
  logic              busy, err;

  imuldiv_muldiv_requester #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_fn(cmd_fn), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_rd(cmd_rd), .cmd_hi(cmd_hi),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
    .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
    .muldivresp_rdy(muldivresp_rdy),
    .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_rd(wb_rd), .wb_data(wb_data),
    .pend_cnt(pend_cnt), .busy(busy), .err(err)
  );

  typedef struct { logic [63:0] res; int rdy_cyc; } unit_t;
  typedef struct { logic [RD_W-1:0] rd; logic [31:0] data; } wb_t;

  unit_t unit_q[$];
  wb_t   sb_q[$];

  int   n_tests = 0, n_fail = 0, cyc = 0, model_pend = 0;
  logic model_err = 1'b0;
  bit   unit_hold = 0, force_resp = 0, expect_wb = 0, prev_stall = 0;
  bit   last_cmd_fire = 0, last_cmd_rdy = 0;
  logic [63:0]     force_result = '0;
  logic [31:0]     prev_data;
  logic [RD_W-1:0] prev_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference mul/div unit: signed MUL product, {rem, quot} for divides.
  function automatic logic [63:0] unit_calc(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [63:0] ea, eb;
    sa = a; sb = b;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    case (fn)
      FUNC_MUL:            return ea * eb;
      FUNC_DIV, FUNC_REM:  return {32'(sa % sb), 32'(sa / sb)};
      default:             return {a % b, a / b};
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input logic [2:0] fn, input logic hi,
                                           input logic [63:0] res);
    logic want_hi;
    if (fn == FUNC_MUL) want_hi = hi;
    else                want_hi = (fn == FUNC_REM) || (fn == FUNC_REMU);
    return want_hi ? res[63:32] : res[31:0];
  endfunction

  // One clock: called at a negedge, drives the unit model, checks, advances to next negedge.
  task automatic cycle();
    bit    resp_fire;
    wb_t   e;
    unit_t u;
    if (force_resp) begin
      muldivresp_val = 1'b1; muldivresp_msg_result = force_result;
    end else if (unit_q.size() > 0 && !unit_hold && unit_q[0].rdy_cyc <= cyc) begin
      muldivresp_val = 1'b1; muldivresp_msg_result = unit_q[0].res;
    end else begin
      muldivresp_val = 1'b0; muldivresp_msg_result = '0;
    end
    #1;
    last_cmd_rdy  = cmd_rdy;
    last_cmd_fire = cmd_val && cmd_rdy;
    check("pend_cnt", 64'(pend_cnt), 64'(model_pend));
    check("err", 64'(err), 64'(model_err));
    if (expect_wb) check("wb_latency", 64'(wb_val), 64'd1);
    if (prev_stall) begin
      check("wb_data_hold", 64'(wb_data), 64'(prev_data));
      check("wb_rd_hold", 64'(wb_rd), 64'(prev_rd));
    end
    if (!reset) begin
      check("req_val_in_reset", 64'(muldivreq_val), 64'd0);
      check("resp_rdy_in_reset", 64'(muldivresp_rdy), 64'd0);
      model_pend = 0; model_err = 1'b0; sb_q.delete(); expect_wb = 0; prev_stall = 0;
    end else begin
      if (model_pend == DEPTH) check("push_when_full", 64'(cmd_rdy), 64'd0);
      if (wb_val && wb_rdy) begin
        if (sb_q.size() == 0) check("wb_unexpected", 64'd1, 64'd0);
        else begin
          e = sb_q.pop_front();
          check("wb_rd", 64'(wb_rd), 64'(e.rd));
          check("wb_data", 64'(wb_data), 64'(e.data));
        end
      end
      resp_fire = muldivresp_val && muldivresp_rdy;
      expect_wb = resp_fire && (model_pend > 0);
      if (resp_fire) begin
        if (!force_resp) void'(unit_q.pop_front());
        if (model_pend > 0) model_pend--;
        else                model_err = 1'b1;
      end
      if (last_cmd_fire) begin
        check("req_val_on_fire", 64'(muldivreq_val), 64'd1);
        u.res = unit_calc(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b);
        u.rdy_cyc = cyc + LAT;
        unit_q.push_back(u);
        e.rd = cmd_rd;
        e.data = exp_data(cmd_fn, cmd_hi, unit_calc(cmd_fn, cmd_a, cmd_b));
        sb_q.push_back(e);
        model_pend++;
      end
      prev_stall = wb_val && !wb_rdy;
      prev_data  = wb_data;
      prev_rd    = wb_rd;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_cmd(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [RD_W-1:0] rd, input logic hi);
    cmd_fn = fn; cmd_a = a; cmd_b = b; cmd_rd = rd; cmd_hi = hi; cmd_val = 1'b1;
  endtask

  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [RD_W-1:0] rd, input logic hi);
    set_cmd(fn, a, b, rd, hi);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (last_cmd_fire) break;
    end
    if (!last_cmd_fire) check("issue_timeout", 64'd0, 64'd1);
    cmd_val = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0 && unit_q.size() == 0 && model_pend == 0 && !wb_val) break;
      cycle();
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b0; cmd_val = 1'b1; cmd_fn = FUNC_MUL; cmd_a = 32'd1; cmd_b = 32'd1;
    cmd_rd = '0; cmd_hi = 1'b0; muldivreq_rdy = 1'b1; wb_rdy = 1'b1;
    muldivresp_val = 1'b0; muldivresp_msg_result = '0;
    @(posedge clk); @(negedge clk);

    // reset state
    cycle();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_wb_val", 64'(wb_val), 64'd0);
    cmd_val = 1'b0; reset = 1'b1;
    cycle();

    // 1..3: basic MUL lo/hi, DIV/REM ordering
    issue(FUNC_MUL, 32'd7, 32'd6, 5'd3, 1'b0);
    drain();
    issue(FUNC_MUL, 32'h8000_0000, 32'd2, 5'd7, 1'b1);
    drain();
    issue(FUNC_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
    issue(FUNC_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0);
    drain();

    // unit not ready blocks the command
    set_cmd(FUNC_DIVU, 32'd100, 32'd7, 5'd9, 1'b0);
    muldivreq_rdy = 1'b0;
    cycle();
    check("cmd_rdy_unit_busy", 64'(last_cmd_rdy), 64'd0);
    muldivreq_rdy = 1'b1;
    issue(FUNC_DIVU, 32'd100, 32'd7, 5'd9, 1'b0);
    drain();

    // random mix, back-to-back
    for (int i = 0; i < 8; i++) begin
      logic [2:0] fn;
      fn = 3'($urandom_range(0, 4));
      issue(fn, $urandom, $urandom | 32'd1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    drain();

    // 4: full FIFO, writeback stall
    unit_hold = 1; wb_rdy = 1'b0;
    issue(FUNC_MUL, 32'd3, 32'd5, 5'd1, 1'b0);
    issue(FUNC_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1);
    set_cmd(FUNC_REMU, 32'd17, 32'd5, 5'd6, 1'b0);
    cycle();
    check("full_cmd_rdy", 64'(last_cmd_rdy), 64'd0);
    check("full_req_val", 64'(muldivreq_val), 64'd0);
    unit_hold = 0;
    issue(FUNC_REMU, 32'd17, 32'd5, 5'd6, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    check("stall_wb_val", 64'(wb_val), 64'd1);
    wb_rdy = 1'b1;
    drain();

    // 5: orphan response
    force_result = 64'h1234; force_resp = 1;
    cycle();
    force_resp = 0;
    cycle();
    check("orphan_err", 64'(err), 64'd1);
    check("orphan_wb_val", 64'(wb_val), 64'd0);
    for (int i = 0; i < 3; i++) cycle();
    check("err_sticky", 64'(err), 64'd1);

    // 6: reset with work in flight
    unit_hold = 1; wb_rdy = 1'b0;
    issue(FUNC_MUL, 32'd2, 32'd3, 5'd10, 1'b0);
    issue(FUNC_MUL, 32'd4, 32'd5, 5'd11, 1'b0);
    unit_hold = 0;
    cycle();
    unit_hold = 1;
    issue(FUNC_MUL, 32'd6, 32'd7, 5'd12, 1'b0);
    check("pre_reset_wb_val", 64'(wb_val), 64'd1);
    check("pre_reset_pend", 64'(pend_cnt), 64'd2);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_wb_val", 64'(wb_val), 64'd0);
    unit_hold = 0; wb_rdy = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    check("late_resp_err", 64'(err), 64'd1);
    check("late_resp_wb_val", 64'(wb_val), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
